// File: rtl/zynet_frame_ctrl.sv
// Frame-level sequencer for the zyNet datapath: frames the host sample stream,
// limits frames in flight, and returns each result vector as scores or as an argmax class.
module zynet_frame_ctrl #(
    parameter int WORD_SIZE     = 16,
    parameter int FRAME_LEN     = 128,
    parameter int OUTPUT_SIZE   = 10,
    parameter int MAX_IN_FLIGHT = 2,
    parameter int MODE          = 0,
    localparam int IDX_W        = $clog2(OUTPUT_SIZE),
    localparam int IF_W         = $clog2(MAX_IN_FLIGHT + 1)
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic [WORD_SIZE-1:0]           s_data_i,
    input  logic                           s_valid_i,
    output logic                           s_ready_o,
    output logic [WORD_SIZE-1:0]           net_data_o,
    output logic                           net_valid_o,
    input  logic                           net_ready_i,
    output logic                           net_start_o,
    input  logic [OUTPUT_SIZE*WORD_SIZE-1:0] net_data_i,
    input  logic                           net_valid_i,
    output logic                           net_yumi_o,
    output logic [WORD_SIZE-1:0]           m_data_o,
    output logic [IDX_W-1:0]               m_idx_o,
    output logic                           m_last_o,
    output logic                           m_valid_o,
    input  logic                           m_yumi_i,
    output logic [IF_W-1:0]                in_flight_o
);

    localparam int CNT_W = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(OUTPUT_SIZE - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IF_W-1:0]  IF_MAX   = IF_W'(MAX_IN_FLIGHT);
    localparam logic [IF_W-1:0]  IF_ONE   = IF_W'(1);

    typedef enum logic [1:0] {
        IN_IDLE  = 2'd0,
        IN_START = 2'd1,
        IN_FILL  = 2'd2
    } in_state_t;

    typedef enum logic [1:0] {
        OUT_IDLE = 2'd0,
        OUT_SCAN = 2'd1,
        OUT_EMIT = 2'd2
    } out_state_t;

    in_state_t                    in_state_r, in_state_s;
    out_state_t                   out_state_r, out_state_s;
    logic [CNT_W-1:0]             cnt_r, cnt_s;
    logic signed [WORD_SIZE-1:0]  vec_r [OUTPUT_SIZE];
    logic [IDX_W-1:0]             k_r, k_s;
    logic signed [WORD_SIZE-1:0]  max_r, max_s;
    logic [IDX_W-1:0]             arg_r, arg_s;
    logic [IF_W-1:0]              in_flight_r, in_flight_s;
    logic                         cap_s;
    logic                         last_s;
    logic                         last_yumi_s;
    logic                         inc_s;
    logic                         dec_s;

    assign net_data_o  = s_data_i;
    assign in_flight_o = in_flight_r;

    // Input FSM: frame start pulse, then pass FRAME_LEN samples through to the network
    always_comb begin
        in_state_s  = in_state_r;
        cnt_s       = cnt_r;
        s_ready_o   = 1'b0;
        net_valid_o = 1'b0;
        net_start_o = 1'b0;
        case (in_state_r)
            IN_IDLE: begin
                if (s_valid_i && (in_flight_r < IF_MAX)) begin
                    in_state_s = IN_START;
                end else begin
                    in_state_s = IN_IDLE;
                end
            end
            IN_START: begin
                net_start_o = 1'b1;
                in_state_s  = IN_FILL;
            end
            IN_FILL: begin
                net_valid_o = s_valid_i;
                s_ready_o   = net_ready_i;
                if (s_valid_i && net_ready_i) begin
                    if (cnt_r == CNT_LAST) begin
                        cnt_s      = '0;
                        in_state_s = IN_IDLE;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end
            default: begin
                in_state_s = IN_IDLE;
                cnt_s      = '0;
            end
        endcase
    end

    // Output FSM: capture the result vector, optionally scan for argmax, then emit
    always_comb begin
        out_state_s = out_state_r;
        k_s         = k_r;
        max_s       = max_r;
        arg_s       = arg_r;
        cap_s       = 1'b0;
        last_s      = 1'b0;
        last_yumi_s = 1'b0;
        net_yumi_o  = 1'b0;
        m_valid_o   = 1'b0;
        m_data_o    = '0;
        m_idx_o     = '0;
        m_last_o    = 1'b0;
        case (out_state_r)
            OUT_IDLE: begin
                net_yumi_o = net_valid_i;
                if (net_valid_i) begin
                    cap_s = 1'b1;
                    max_s = net_data_i[WORD_SIZE-1:0];
                    arg_s = '0;
                    if (MODE == 1) begin
                        out_state_s = OUT_SCAN;
                        k_s         = IDX_ONE;
                    end else begin
                        out_state_s = OUT_EMIT;
                        k_s         = '0;
                    end
                end else begin
                    out_state_s = OUT_IDLE;
                end
            end
            OUT_SCAN: begin
                // Strict signed compare keeps the lowest index on ties
                if (vec_r[k_r] > max_r) begin
                    max_s = vec_r[k_r];
                    arg_s = k_r;
                end else begin
                    max_s = max_r;
                    arg_s = arg_r;
                end
                if (k_r == IDX_LAST) begin
                    out_state_s = OUT_EMIT;
                end else begin
                    k_s = k_r + IDX_ONE;
                end
            end
            OUT_EMIT: begin
                m_valid_o = 1'b1;
                if (MODE == 1) begin
                    m_data_o = max_r;
                    m_idx_o  = arg_r;
                    last_s   = 1'b1;
                end else begin
                    m_data_o = vec_r[k_r];
                    m_idx_o  = k_r;
                    last_s   = (k_r == IDX_LAST);
                end
                m_last_o = last_s;
                if (m_yumi_i) begin
                    if (last_s) begin
                        out_state_s = OUT_IDLE;
                        last_yumi_s = 1'b1;
                    end else begin
                        k_s = k_r + IDX_ONE;
                    end
                end else begin
                    out_state_s = OUT_EMIT;
                end
            end
            default: begin
                out_state_s = OUT_IDLE;
            end
        endcase
    end

    // In-flight credit update; the decrement saturates so an unsolicited result cannot underflow
    always_comb begin
        inc_s       = (in_state_r == IN_START);
        dec_s       = last_yumi_s && (in_flight_r != '0);
        in_flight_s = in_flight_r;
        case ({inc_s, dec_s})
            2'b10:   in_flight_s = in_flight_r + IF_ONE;
            2'b01:   in_flight_s = in_flight_r - IF_ONE;
            default: in_flight_s = in_flight_r;
        endcase
    end

    // State, frame counter and credit registers
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            in_state_r  <= IN_IDLE;
            out_state_r <= OUT_IDLE;
            cnt_r       <= '0;
            in_flight_r <= '0;
        end else begin
            in_state_r  <= in_state_s;
            out_state_r <= out_state_s;
            cnt_r       <= cnt_s;
            in_flight_r <= in_flight_s;
        end
    end

    // Captured result vector and scan/emit datapath registers
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < OUTPUT_SIZE; i++) begin
                vec_r[i] <= '0;
            end
            k_r   <= '0;
            max_r <= '0;
            arg_r <= '0;
        end else begin
            if (cap_s) begin
                for (int i = 0; i < OUTPUT_SIZE; i++) begin
                    vec_r[i] <= net_data_i[i*WORD_SIZE +: WORD_SIZE];
                end
            end
            k_r   <= k_s;
            max_r <= max_s;
            arg_r <= arg_s;
        end
    end

endmodule

// File: tb/tb_zynet_frame_ctrl.sv
// Scoreboard bench for zynet_frame_ctrl: one MODE0 instance exercising framing, backpressure
// and credits, plus a MODE1 instance for argmax results.
module tb_zynet_frame_ctrl;

    localparam int W     = 16;
    localparam int FL    = 128;
    localparam int OS    = 10;
    localparam int MIF   = 2;
    localparam int IDX_W = 4;
    localparam int IF_W  = 2;

    typedef struct packed {
        logic [W-1:0]     d;
        logic [IDX_W-1:0] idx;
        logic             last;
    } exp_t;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic                reset_n_i;
    logic [W-1:0]        s_data_i;
    logic                s_valid_i;
    logic                s_ready_o;
    logic [W-1:0]        net_data_o;
    logic                net_valid_o;
    logic                net_ready_i;
    logic                net_start_o;
    logic [OS*W-1:0]     net_data_i;
    logic                net_valid_i;
    logic                net_yumi_o;
    logic [W-1:0]        m_data_o;
    logic [IDX_W-1:0]    m_idx_o;
    logic                m_last_o;
    logic                m_valid_o;
    logic                m_yumi_i;
    logic [IF_W-1:0]     in_flight_o;

    logic [W-1:0]        s_data_b;
    logic                s_valid_b;
    logic                s_ready_b;
    logic [W-1:0]        net_data_ob;
    logic                net_valid_ob;
    logic                net_ready_b;
    logic                net_start_b;
    logic [OS*W-1:0]     net_data_b;
    logic                net_valid_b;
    logic                net_yumi_b;
    logic [W-1:0]        m_data_b;
    logic [IDX_W-1:0]    m_idx_b;
    logic                m_last_b;
    logic                m_valid_b;
    logic                m_yumi_b;
    logic [IF_W-1:0]     in_flight_b;

    zynet_frame_ctrl #(.WORD_SIZE(W), .FRAME_LEN(FL), .OUTPUT_SIZE(OS),
                       .MAX_IN_FLIGHT(MIF), .MODE(0)) dut0 (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
        .net_data_o(net_data_o), .net_valid_o(net_valid_o), .net_ready_i(net_ready_i),
        .net_start_o(net_start_o), .net_data_i(net_data_i), .net_valid_i(net_valid_i),
        .net_yumi_o(net_yumi_o), .m_data_o(m_data_o), .m_idx_o(m_idx_o),
        .m_last_o(m_last_o), .m_valid_o(m_valid_o), .m_yumi_i(m_yumi_i),
        .in_flight_o(in_flight_o)
    );

    zynet_frame_ctrl #(.WORD_SIZE(W), .FRAME_LEN(FL), .OUTPUT_SIZE(OS),
                       .MAX_IN_FLIGHT(MIF), .MODE(1)) dut1 (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .s_data_i(s_data_b), .s_valid_i(s_valid_b), .s_ready_o(s_ready_b),
        .net_data_o(net_data_ob), .net_valid_o(net_valid_ob), .net_ready_i(net_ready_b),
        .net_start_o(net_start_b), .net_data_i(net_data_b), .net_valid_i(net_valid_b),
        .net_yumi_o(net_yumi_b), .m_data_o(m_data_b), .m_idx_o(m_idx_b),
        .m_last_o(m_last_b), .m_valid_o(m_valid_b), .m_yumi_i(m_yumi_b),
        .in_flight_o(in_flight_b)
    );

    exp_t         q0[$];
    exp_t         q1[$];
    logic [W-1:0] in_q[$];
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int seq = 0;
    int starts = 0, accepts = 0, frame_acc = 0;
    int mirror_bad = 0, stab_bad0 = 0, stab_bad1 = 0;
    int yumi_cyc0 = 0, yumi_cyc1 = 0;
    bit fill_exp = 1'b0;
    logic             pv0 = 1'b0, py0 = 1'b0, pl0 = 1'b0;
    logic [W-1:0]     pd0 = '0;
    logic [IDX_W-1:0] pi0 = '0;
    logic             pv1 = 1'b0, py1 = 1'b0, pl1 = 1'b0;
    logic [W-1:0]     pd1 = '0;
    logic [IDX_W-1:0] pi1 = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [OS*W-1:0] pack10(input int a0, input int a1, input int a2,
            input int a3, input int a4, input int a5, input int a6, input int a7,
            input int a8, input int a9);
        int a[OS];
        logic [OS*W-1:0] r;
        a = '{a0, a1, a2, a3, a4, a5, a6, a7, a8, a9};
        r = '0;
        for (int k = 0; k < OS; k++) r[k*W +: W] = W'(a[k]);
        return r;
    endfunction

    always @(posedge clk_i) cyc <= cyc + 1;

    // Monitor: input-side accounting and output scoreboards for both instances
    always @(negedge clk_i) begin
        exp_t e;
        if (fill_exp && (s_ready_o !== net_ready_i)) mirror_bad++;
        if (s_valid_i && s_ready_o) begin
            accepts++;
            if (in_q.size() == 0) begin
                check("accept_unexpected", 32'd1, 32'd0);
            end else begin
                check("net_data", 32'(net_data_o), 32'(in_q.pop_front()));
                check("net_valid", 32'(net_valid_o), 32'd1);
            end
            frame_acc++;
            if (frame_acc == FL) begin
                frame_acc = 0;
                fill_exp  = 1'b0;
            end
        end
        if (net_start_o) begin
            starts++;
            fill_exp = 1'b1;
        end
        if (!reset_n_i) begin
            fill_exp  = 1'b0;
            frame_acc = 0;
        end

        if (net_yumi_o) yumi_cyc0 = cyc;
        if (m_valid_o && !pv0) check("latency0", 32'(cyc - yumi_cyc0), 32'd1);
        if (pv0 && !py0 && ({m_valid_o, m_data_o, m_idx_o, m_last_o} !== {1'b1, pd0, pi0, pl0}))
            stab_bad0++;
        if (m_valid_o && m_yumi_i) begin
            if (q0.size() == 0) begin
                check("out0_unexpected", 32'd1, 32'd0);
            end else begin
                e = q0.pop_front();
                check("out0_data", 32'(m_data_o), 32'(e.d));
                check("out0_idx", 32'(m_idx_o), 32'(e.idx));
                check("out0_last", 32'(m_last_o), 32'(e.last));
            end
        end
        pv0 = m_valid_o; py0 = m_yumi_i; pd0 = m_data_o; pi0 = m_idx_o; pl0 = m_last_o;

        if (net_yumi_b) yumi_cyc1 = cyc;
        if (m_valid_b && !pv1) check("latency1", 32'(cyc - yumi_cyc1), 32'(OS));
        if (pv1 && !py1 && ({m_valid_b, m_data_b, m_idx_b, m_last_b} !== {1'b1, pd1, pi1, pl1}))
            stab_bad1++;
        if (m_valid_b && m_yumi_b) begin
            if (q1.size() == 0) begin
                check("out1_unexpected", 32'd1, 32'd0);
            end else begin
                e = q1.pop_front();
                check("out1_data", 32'(m_data_b), 32'(e.d));
                check("out1_idx", 32'(m_idx_b), 32'(e.idx));
                check("out1_last", 32'(m_last_b), 32'(e.last));
            end
        end
        pv1 = m_valid_b; py1 = m_yumi_b; pd1 = m_data_b; pi1 = m_idx_b; pl1 = m_last_b;
    end

    task automatic send_samples(input int n, input bit bp);
        int sent = 0;
        int budget = 0;
        bit acc;
        while (sent < n && budget < 4000) begin
            s_data_i  = W'(seq * 7 + 3);
            s_valid_i = 1'b1;
            in_q.push_back(s_data_i);
            acc = 1'b0;
            while (!acc && budget < 4000) begin
                net_ready_i = bp ? ~net_ready_i : 1'b1;
                @(negedge clk_i);
                acc = s_ready_o;
                @(posedge clk_i); #1;
                budget++;
            end
            if (acc) begin
                sent++;
                seq++;
            end
        end
        s_valid_i   = 1'b0;
        net_ready_i = 1'b1;
        check("send_count", 32'(sent), 32'(n));
    endtask

    task automatic drain0(input logic [OS*W-1:0] vec, input bit alt);
        int budget = 0;
        bit got = 1'b0, done = 1'b0, phase = 1'b0;
        exp_t e;
        for (int k = 0; k < OS; k++) begin
            e.d    = vec[k*W +: W];
            e.idx  = IDX_W'(k);
            e.last = (k == OS - 1);
            q0.push_back(e);
        end
        net_data_i  = vec;
        net_valid_i = 1'b1;
        while (!got && budget < 200) begin
            @(negedge clk_i);
            got = net_yumi_o;
            @(posedge clk_i); #1;
            budget++;
        end
        net_valid_i = 1'b0;
        check("yumi0", 32'(got), 32'd1);
        budget = 0;
        while (!done && budget < 200) begin
            phase    = ~phase;
            m_yumi_i = (alt ? phase : 1'b1) & m_valid_o;
            @(negedge clk_i);
            done = m_yumi_i && m_last_o;
            @(posedge clk_i); #1;
            budget++;
        end
        m_yumi_i = 1'b0;
        check("drain0_done", 32'(done), 32'd1);
    endtask

    task automatic drain1(input logic [OS*W-1:0] vec, input int exp_d, input int exp_idx);
        int budget = 0;
        bit got = 1'b0;
        exp_t e;
        e.d    = W'(exp_d);
        e.idx  = IDX_W'(exp_idx);
        e.last = 1'b1;
        q1.push_back(e);
        net_data_b  = vec;
        net_valid_b = 1'b1;
        while (!got && budget < 200) begin
            @(negedge clk_i);
            got = net_yumi_b;
            @(posedge clk_i); #1;
            budget++;
        end
        net_valid_b = 1'b0;
        check("yumi1", 32'(got), 32'd1);
        got = 1'b0;
        budget = 0;
        while (!got && budget < 200) begin
            @(negedge clk_i);
            got = m_valid_b;
            @(posedge clk_i); #1;
            budget++;
        end
        check("valid1", 32'(got), 32'd1);
        repeat (3) begin
            @(posedge clk_i); #1;
        end
        m_yumi_b = m_valid_b;
        @(posedge clk_i); #1;
        m_yumi_b = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        @(negedge clk_i);
        check({tag, "_in"}, 32'({s_ready_o, net_valid_o, net_start_o, net_yumi_o}), 32'd0);
        check({tag, "_out"}, 32'({m_valid_o, m_data_o, m_idx_o, m_last_o}), 32'd0);
        check({tag, "_flight"}, 32'(in_flight_o), 32'd0);
        check({tag, "_b"}, 32'({s_ready_b, net_start_b, m_valid_b, m_data_b, in_flight_b}), 32'd0);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk_i); #1;
        end
    endtask

    initial begin
        int s0, a0;
        reset_n_i = 1'b0; s_data_i = '0; s_valid_i = 1'b0; net_ready_i = 1'b1;
        net_data_i = '0; net_valid_i = 1'b0; m_yumi_i = 1'b0;
        s_data_b = '0; s_valid_b = 1'b0; net_ready_b = 1'b1;
        net_data_b = '0; net_valid_b = 1'b0; m_yumi_b = 1'b0;
        idle_cycles(3);
        check_quiet("reset");
        @(posedge clk_i); #1;
        reset_n_i = 1'b1;
        idle_cycles(2);

        // Reset in the middle of a frame (cnt = 50)
        send_samples(50, 1'b0);
        @(negedge clk_i);
        check("partial_flight", 32'(in_flight_o), 32'd1);
        @(posedge clk_i); #1;
        reset_n_i = 1'b0;
        @(posedge clk_i); #1;
        s_valid_i = 1'b1;
        check_quiet("midreset");
        @(posedge clk_i); #1;
        s_valid_i = 1'b0;
        reset_n_i = 1'b1;
        idle_cycles(2);

        // Full back-to-back frame after the reset
        s0 = starts; a0 = accepts;
        send_samples(FL, 1'b0);
        idle_cycles(3);
        @(negedge clk_i);
        check("frame1_starts", 32'(starts - s0), 32'd1);
        check("frame1_accepts", 32'(accepts - a0), 32'(FL));
        check("frame1_flight", 32'(in_flight_o), 32'd1);

        // Frame under toggling backpressure
        s0 = starts; a0 = accepts;
        send_samples(FL, 1'b1);
        idle_cycles(3);
        @(negedge clk_i);
        check("bp_starts", 32'(starts - s0), 32'd1);
        check("bp_accepts", 32'(accepts - a0), 32'(FL));
        check("bp_mirror", 32'(mirror_bad), 32'd0);
        check("bp_flight", 32'(in_flight_o), 32'd2);

        // Third frame stalls on credits until one result drains
        s0 = starts; a0 = accepts;
        s_valid_i = 1'b1;
        s_data_i  = 16'hDEAD;
        idle_cycles(20);
        @(negedge clk_i);
        check("credit_stall_starts", 32'(starts - s0), 32'd0);
        check("credit_stall_accepts", 32'(accepts - a0), 32'd0);
        check("credit_stall_flight", 32'(in_flight_o), 32'd2);
        @(posedge clk_i); #1;
        fork
            drain0(pack10(-5, -2, 1, 4, 7, 10, 13, 16, 19, 22), 1'b1);
            send_samples(FL, 1'b0);
        join
        idle_cycles(3);
        @(negedge clk_i);
        check("credit_starts", 32'(starts - s0), 32'd1);
        check("credit_accepts", 32'(accepts - a0), 32'(FL));
        check("credit_flight", 32'(in_flight_o), 32'd2);

        // Drain the remaining results, then one unsolicited result with no credit outstanding
        @(posedge clk_i); #1;
        drain0(pack10(32767, -32768, 0, 1, -1, 100, -100, 2, -2, 7), 1'b0);
        drain0(pack10(9, 8, 7, 6, 5, 4, 3, 2, 1, 0), 1'b1);
        idle_cycles(2);
        @(negedge clk_i);
        check("drained_flight", 32'(in_flight_o), 32'd0);
        @(posedge clk_i); #1;
        drain0(pack10(1, 2, 3, 4, 5, 6, 7, 8, 9, 10), 1'b0);
        idle_cycles(2);
        @(negedge clk_i);
        check("underflow_flight", 32'(in_flight_o), 32'd0);

        // Argmax instance: tie to lowest index, all-negative with max at the end, all equal
        @(posedge clk_i); #1;
        drain1(pack10(3, -7, 9, 9, 0, 0, 0, 0, 0, 0), 9, 2);
        drain1(pack10(-8, -3, -3, -20, -5, -6, -7, -9, -10, -1), -1, 9);
        drain1(pack10(5, 5, 5, 5, 5, 5, 5, 5, 5, 5), 5, 0);
        idle_cycles(3);
        @(negedge clk_i);
        check("argmax_flight", 32'(in_flight_b), 32'd0);

        check("q0_empty", 32'(q0.size()), 32'd0);
        check("q1_empty", 32'(q1.size()), 32'd0);
        check("in_q_empty", 32'(in_q.size()), 32'd0);
        check("mirror_total", 32'(mirror_bad), 32'd0);
        check("stable0", 32'(stab_bad0), 32'd0);
        check("stable1", 32'(stab_bad1), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
